// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-core main-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 12;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MEM_LAT_DEF = 2;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_id = (last == REQ_ID0) ? REQ_ID1 : REQ_ID0;
        end else begin
            grant_id = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises both cores' cache-controller traffic onto the single-port main memory,
// returning a one-cycle ack and invalidating the other core's line on every write.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              inv0,
    output logic              inv1,
    output logic [ADDR_W-1:0] inv_addr,
    output logic              busy
);

    arb_state_t        r_state;
    logic              r_last;
    logic              r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;

    arb_state_t        w_state_next;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_load;
    logic              w_capture;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_enter_done;

    rr_pick2 u_pick (
        .req         ({req1, req0}),
        .last        (r_last),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    assign w_sel_we    = (w_grant_id == REQ_ID1) ? we1    : we0;
    assign w_sel_addr  = (w_grant_id == REQ_ID1) ? addr1  : addr0;
    assign w_sel_wdata = (w_grant_id == REQ_ID1) ? wdata1 : wdata0;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = ISSUE;
                    w_load       = 1'b1;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = WAIT;
                    w_cnt_next   = CNT_W'(MEM_LAT - 1);
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_enter_done = (w_state_next == DONE);

    // Outputs are registered from the next-state decision so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last   <= REQ_ID1;
            r_id     <= REQ_ID0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            inv0     <= 1'b0;
            inv1     <= 1'b0;
            inv_addr <= '0;
            busy     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_load) begin
                r_id     <= w_grant_id;
                r_we     <= w_sel_we;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
                mem_addr <= w_sel_addr;
                mem_data <= w_sel_wdata;
            end
            mem_rden <= w_load & ~w_sel_we;
            mem_wren <= w_load &  w_sel_we;
            if (w_capture) begin
                if (r_id == REQ_ID1) rdata1 <= mem_q;
                else                 rdata0 <= mem_q;
            end
            ack0 <= w_enter_done & (r_id == REQ_ID0);
            ack1 <= w_enter_done & (r_id == REQ_ID1);
            inv0 <= w_enter_done & r_we & (r_id == REQ_ID1);
            inv1 <= w_enter_done & r_we & (r_id == REQ_ID0);
            if (w_enter_done && r_we) inv_addr <= r_addr;
            if (r_state == DONE) r_last <= r_id;
            busy <= (w_state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model plus per-cycle compare and directed scenarios.
module tb_mem_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_rden, mem_wren;
    logic [DW-1:0] mem_q;
    logic          inv0, inv1;
    logic [AW-1:0] inv_addr;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
        .inv0(inv0), .inv1(inv1), .inv_addr(inv_addr), .busy(busy)
    );

    // Main memory with registered address and registered output (two-cycle read).
    logic [DW-1:0] mem [0:4095];
    logic [AW-1:0] mem_ra;
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        if (mem_rden) mem_ra <= mem_addr;
        mem_q <= mem[mem_ra];
    end

    function automatic logic [DW-1:0] preload(int i);
        if (i == 'h0A4) return 32'hDEADBEEF;
        return 32'hA5A50000 ^ i;
    endfunction

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t          q0[$];
    txn_t          q1[$];
    logic [DW-1:0] shadow [0:4095];

    int            cyc = 0;
    bit            m_active = 0;
    bit            m_id, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_start;
    bit            m_last = 1;
    logic [DW-1:0] m_rdata0 = '0;
    logic [DW-1:0] m_rdata1 = '0;

    int errors = 0;
    int checks = 0;

    int            n_rden, n_wren, n_inv0, n_inv1, n_both, n_busy_lo, n_acks, n_ack0;
    int            ack0_cyc, ack1_cyc, inv0_cyc, inv1_cyc;
    logic [AW-1:0] rden_addr, inv_addr_seen;
    logic [DW-1:0] wren_data;
    logic [11:0]   order;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ack_off(bit we);
        return we ? 2 : 2 + LAT;
    endfunction

    task automatic drive_pins();
        req0 = (q0.size() != 0);
        req1 = (q1.size() != 0);
        we0 = 0; addr0 = '0; wdata0 = '0;
        we1 = 0; addr1 = '0; wdata1 = '0;
        if (req0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
        if (req1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
    endtask

    task automatic push(bit core, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        if (core) q1.push_back(t);
        else      q0.push_back(t);
        drive_pins();
    endtask

    task automatic clr();
        n_rden = 0; n_wren = 0; n_inv0 = 0; n_inv1 = 0; n_both = 0;
        n_busy_lo = 0; n_acks = 0; n_ack0 = 0;
        ack0_cyc = -1000; ack1_cyc = -1000; inv0_cyc = -1000; inv1_cyc = -1000;
        rden_addr = '0; inv_addr_seen = '0; wren_data = '0; order = '0;
    endtask

    // One clock: model decision for the coming edge, then compare the new cycle's outputs.
    task automatic step();
        int off;
        bit e_busy, e_rden, e_wren, e_ack0, e_ack1, e_inv0, e_inv1;
        if (rst) begin
            m_active = 0; m_last = 1; m_rdata0 = '0; m_rdata1 = '0;
        end else if (m_active && (cyc - m_start) == ack_off(m_we)) begin
            m_active = 0; m_last = m_id;
        end else if (!m_active && (req0 || req1)) begin
            m_id = (req0 && req1) ? ~m_last : req1;
            if (m_id) begin m_we = q1[0].we; m_addr = q1[0].addr; m_wdata = q1[0].wdata; end
            else      begin m_we = q0[0].we; m_addr = q0[0].addr; m_wdata = q0[0].wdata; end
            m_start  = cyc;
            m_active = 1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        e_busy = 0; e_rden = 0; e_wren = 0; e_ack0 = 0; e_ack1 = 0; e_inv0 = 0; e_inv1 = 0;
        off = cyc - m_start;
        if (m_active) begin
            e_busy = 1;
            e_rden = (off == 1) && !m_we;
            e_wren = (off == 1) && m_we;
            if (off == ack_off(m_we)) begin
                if (m_id) e_ack1 = 1; else e_ack0 = 1;
                if (m_we) begin
                    if (m_id) e_inv0 = 1; else e_inv1 = 1;
                    shadow[m_addr] = m_wdata;
                end else if (m_id) m_rdata1 = shadow[m_addr];
                else               m_rdata0 = shadow[m_addr];
            end
        end
        chk("busy", busy, e_busy);
        chk("mem_rden", mem_rden, e_rden);
        chk("mem_wren", mem_wren, e_wren);
        chk("ack0", ack0, e_ack0);
        chk("ack1", ack1, e_ack1);
        chk("inv0", inv0, e_inv0);
        chk("inv1", inv1, e_inv1);
        chk("rdata0", rdata0, m_rdata0);
        chk("rdata1", rdata1, m_rdata1);
        if (e_busy) chk("mem_addr", mem_addr, m_addr);
        if (e_wren) chk("mem_data", mem_data, m_wdata);
        if (e_inv0 || e_inv1) chk("inv_addr", inv_addr, m_addr);

        if (mem_rden) begin n_rden++; rden_addr = mem_addr; end
        if (mem_wren) begin n_wren++; wren_data = mem_data; end
        if (ack0) begin ack0_cyc = cyc; n_ack0++; n_acks++; order = {order[10:0], 1'b0}; end
        if (ack1) begin ack1_cyc = cyc; n_acks++; order = {order[10:0], 1'b1}; end
        if (ack0 && ack1) n_both++;
        if (inv0) begin n_inv0++; inv0_cyc = cyc; inv_addr_seen = inv_addr; end
        if (inv1) begin n_inv1++; inv1_cyc = cyc; inv_addr_seen = inv_addr; end
        if (!busy) n_busy_lo++;

        if (e_ack0) void'(q0.pop_front());
        if (e_ack1) void'(q1.pop_front());
        drive_pins();
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = preload(i);
            shadow[i] = preload(i);
        end
        rst = 1;
        drive_pins();
        clr();
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_ack", {ack1, ack0}, 0);
        chk("reset_rdata0", rdata0, 0);
        rst = 0;
        step();

        // Single read by core 0
        clr();
        push(0, 0, 12'h0A4, '0);
        k = cyc;
        repeat (8) step();
        chk("rd_ack_lat", ack0_cyc - k, 4);
        chk("rd_rden_cnt", n_rden, 1);
        chk("rd_mem_addr", rden_addr, 12'h0A4);
        chk("rd_rdata0", rdata0, 32'hDEADBEEF);
        chk("rd_no_inv", n_inv0 + n_inv1, 0);

        // Single write by core 1
        clr();
        push(1, 1, 12'h3FF, 32'h12345678);
        k = cyc;
        repeat (6) step();
        chk("wr_ack_lat", ack1_cyc - k, 2);
        chk("wr_wren_cnt", n_wren, 1);
        chk("wr_mem_data", wren_data, 32'h12345678);
        chk("wr_inv0_cyc", inv0_cyc - k, 2);
        chk("wr_inv_addr", inv_addr_seen, 12'h3FF);
        chk("wr_no_inv1", n_inv1, 0);

        // Tie straight after reset
        do_reset();
        clr();
        push(0, 0, 12'h020, '0);
        push(1, 0, 12'h021, '0);
        k = cyc;
        repeat (12) step();
        chk("tie_order", order[1:0], 2'b01);
        chk("tie_ack0_lat", ack0_cyc - k, 4);
        chk("tie_ack1_lat", ack1_cyc - k, 9);
        chk("tie_no_dual_ack", n_both, 0);
        chk("tie_rdata1", rdata1, 32'hA5A50021);

        // Sustained contention: core 0 writes, core 1 reads, six each
        do_reset();
        clr();
        for (int i = 0; i < 6; i++) begin
            push(0, 1, 12'(12'h100 + i), 32'(32'h11110000 + i));
            push(1, 0, 12'(12'h200 + i), '0);
        end
        k = cyc;
        repeat (47) step();
        chk("sus_order", order, 12'h555);
        chk("sus_acks", n_acks, 12);
        chk("sus_total", ack1_cyc - k, 47);
        chk("sus_gaps", n_busy_lo, 11);
        repeat (4) step();

        // Coherence: write and read of the same line in the same cycle
        do_reset();
        clr();
        push(0, 1, 12'h010, 32'h55);
        push(1, 0, 12'h010, '0);
        k = cyc;
        repeat (10) step();
        chk("coh_order", order[1:0], 2'b01);
        chk("coh_ack0_lat", ack0_cyc - k, 2);
        chk("coh_inv1_cyc", inv1_cyc - k, 2);
        chk("coh_ack1_lat", ack1_cyc - k, 7);
        chk("coh_rdata1", rdata1, 32'h55);

        // Reset during the read wait
        do_reset();
        clr();
        push(0, 0, 12'h0A4, '0);
        k = cyc;
        repeat (2) step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_no_ack0", n_ack0, 0);
        chk("rst_rdata0", rdata0, 0);
        k = cyc;
        repeat (8) step();
        chk("rst_reissue_lat", ack0_cyc - k, 4);
        chk("rst_reissue_data", rdata0, 32'hDEADBEEF);
        chk("rst_reissue_acks", n_ack0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
